id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- Parametrised ID/EX pipeline stage register for the MIPS core. Carries the decoded control bundle and the operand/address payload from decode to execute.
- Adds things the fixed-width stage does not have: valid/ready handshake, a one-entry skid buffer, hazard-driven NOP bubble insertion and synchronous flush.
- Sits between the decode/hazard unit and the EX stage / forwarding unit.

Parameters:
- DATA_W, 32, width of PC, register-read data and immediate
- REG_AW, 5, register address width
- NUM_SRC, 2, number of source operands (read data and source address per operand)
- CTRL_W, 13, control bundle width {RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDest, ALUOp[5:0], ALUSrc}
- CTRL_NOP, 13'b0, control value presented for bubbles, flushes, reset and invalid slots

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_ctrl  in  CTRL_W  decoded control bundle
- in_pc  in  DATA_W  instruction address
- in_rdata  in  NUM_SRC*DATA_W  register-file read data, operand 0 in LSBs
- in_imm  in  DATA_W  sign-extended immediate
- in_rs  in  NUM_SRC*REG_AW  source register addresses (for forwarding)
- in_rd  in  2*REG_AW  destination candidates {rd, rt}
- bubble  in  1  hazard unit requests NOP insertion; decode is held
- flush  in  1  branch/exception flush
- out_valid  out  1  EX-stage entry valid
- out_ready  in  1  EX stage consumes
- out_ctrl, out_pc, out_rdata, out_imm, out_rs, out_rd  out  same widths as inputs  registered payload

Behaviour:
- Storage: main entry M (drives the outputs) and skid entry S; each has a valid bit.
- Reset (async, rst=1): M and S invalid; out_valid=0; out_ctrl=CTRL_NOP; all data outputs 0; in_ready=1 once rst deasserts.
- in_ready = ~S.valid & ~bubble & ~flush (combinational). Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Latency: 1 cycle from accept to out_valid when M is free. Throughput: 1 per cycle with out_ready held high.
- Accept routing, with order always preserved:
  - M empty, or M draining with S empty: input loads M.
  - M valid and not draining: input loads S.
  - M draining with S valid: S moves to M; in_ready was already 0, so no accept happens.
- Bubble (level): while bubble=1, decode is held (in_ready=0).
  - In each cycle where S is empty and M is empty or draining, M loads a NOP entry: valid=1, ctrl=CTRL_NOP, data 0.
  - If bubble stays high, one NOP is inserted per free cycle.
  - If S is valid, bubble waits until S has drained.
- Flush (synchronous) has highest priority, over bubble, accept and drain. On the next edge M and S go invalid. The input in the flush cycle is dropped and in_ready=0 during flush.
- out_ctrl = M.valid ? M.ctrl : CTRL_NOP, so invalid slots never assert RegWrite or MemWrite. Data outputs hold their last loaded value while invalid.
- out_valid=1 with out_ready=0: all outputs stable until drained.
- rst mid-operation: both entries are discarded immediately, including an in-flight skid entry.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Defined: adds two outputs.
  - stall_cnt, 32 bits: counts cycles with out_valid & ~out_ready.
  - bubble_cnt, 32 bits: counts NOP insertions.
  - Both reset to 0 on rst and on flush, and wrap modulo 2^32.
- Undefined: no counters and no extra ports; behaviour otherwise identical.

Test Plan:
- Reset, then in_valid=1 with in_pc=0x100 and ctrl=13'h1A05, out_ready=1 -> next cycle out_valid=1, out_pc=0x100, out_ctrl=13'h1A05; in_ready stays 1.
- Back-to-back PCs 0x100, 0x104, 0x108 with out_ready=0 from cycle 1 -> 0x100 held in M, 0x104 in S, in_ready=0. Raise out_ready -> outputs 0x100, 0x104, 0x108 in order with no loss and no duplicate.
- bubble=1 for 2 cycles while in_valid=1 (pc 0x200), out_ready=1 -> two entries with out_valid=1, out_ctrl=0; then pc 0x200 issues. bubble_cnt=2 when ID_EX_PERF_EN is defined.
- M valid (pc 0x300) and S valid (pc 0x304), assert flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; no 0x30x entry appears afterwards.
- Assert rst asynchronously mid-cycle with M valid -> out_valid=0 and out_ctrl=0 before the next clock edge.
- out_ready=0 for 5 cycles with M valid -> stall_cnt=5 (ID_EX_PERF_EN defined); out_pc stable throughout.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline stage register: valid/ready handshake, one-entry skid buffer,
// hazard NOP bubbles and synchronous flush. Define ID_EX_PERF_EN for stall/bubble counters.
module id_ex_stage_reg #(
    parameter int unsigned         DATA_W   = 32,
    parameter int unsigned         REG_AW   = 5,
    parameter int unsigned         NUM_SRC  = 2,
    parameter int unsigned         CTRL_W   = 13,
    parameter logic [CTRL_W-1:0]   CTRL_NOP = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CTRL_W-1:0]           in_ctrl,
    input  logic [DATA_W-1:0]           in_pc,
    input  logic [NUM_SRC*DATA_W-1:0]   in_rdata,
    input  logic [DATA_W-1:0]           in_imm,
    input  logic [NUM_SRC*REG_AW-1:0]   in_rs,
    input  logic [2*REG_AW-1:0]         in_rd,
    input  logic                        bubble,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CTRL_W-1:0]           out_ctrl,
    output logic [DATA_W-1:0]           out_pc,
    output logic [NUM_SRC*DATA_W-1:0]   out_rdata,
    output logic [DATA_W-1:0]           out_imm,
    output logic [NUM_SRC*REG_AW-1:0]   out_rs,
    output logic [2*REG_AW-1:0]         out_rd
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]                 stall_cnt,
    output logic [31:0]                 bubble_cnt
`endif
);

    logic                        m_valid, s_valid;
    logic [CTRL_W-1:0]           m_ctrl, s_ctrl;
    logic [DATA_W-1:0]           m_pc, s_pc;
    logic [NUM_SRC*DATA_W-1:0]   m_rdata, s_rdata;
    logic [DATA_W-1:0]           m_imm, s_imm;
    logic [NUM_SRC*REG_AW-1:0]   m_rs, s_rs;
    logic [2*REG_AW-1:0]         m_rd, s_rd;

    logic accept, drain, m_free, nop_ins;

    assign in_ready = ~s_valid & ~bubble & ~flush;
    assign accept   = in_valid & in_ready;
    assign drain    = m_valid & out_ready;
    assign m_free   = ~m_valid | drain;
    // A pending skid entry must leave before any bubble may enter, keeping order.
    assign nop_ins  = ~flush & ~s_valid & bubble & m_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_ctrl  <= CTRL_NOP;
            m_pc    <= '0;
            m_rdata <= '0;
            m_imm   <= '0;
            m_rs    <= '0;
            m_rd    <= '0;
            s_valid <= 1'b0;
            s_ctrl  <= CTRL_NOP;
            s_pc    <= '0;
            s_rdata <= '0;
            s_imm   <= '0;
            s_rs    <= '0;
            s_rd    <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (s_valid) begin
            if (drain) begin
                m_ctrl  <= s_ctrl;
                m_pc    <= s_pc;
                m_rdata <= s_rdata;
                m_imm   <= s_imm;
                m_rs    <= s_rs;
                m_rd    <= s_rd;
                s_valid <= 1'b0;
            end
        end else if (nop_ins) begin
            m_valid <= 1'b1;
            m_ctrl  <= CTRL_NOP;
            m_pc    <= '0;
            m_rdata <= '0;
            m_imm   <= '0;
            m_rs    <= '0;
            m_rd    <= '0;
        end else if (accept) begin
            if (m_free) begin
                m_valid <= 1'b1;
                m_ctrl  <= in_ctrl;
                m_pc    <= in_pc;
                m_rdata <= in_rdata;
                m_imm   <= in_imm;
                m_rs    <= in_rs;
                m_rd    <= in_rd;
            end else begin
                s_valid <= 1'b1;
                s_ctrl  <= in_ctrl;
                s_pc    <= in_pc;
                s_rdata <= in_rdata;
                s_imm   <= in_imm;
                s_rs    <= in_rs;
                s_rd    <= in_rd;
            end
        end else if (drain) begin
            m_valid <= 1'b0;
        end
    end

    assign out_valid = m_valid;
    assign out_ctrl  = m_valid ? m_ctrl : CTRL_NOP;
    assign out_pc    = m_pc;
    assign out_rdata = m_rdata;
    assign out_imm   = m_imm;
    assign out_rs    = m_rs;
    assign out_rd    = m_rd;

`ifdef ID_EX_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (flush) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (m_valid & ~out_ready)
                stall_cnt <= stall_cnt + 32'd1;
            if (nop_ins)
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg with an in-order scoreboard of expected EX entries.
module tb_id_ex_stage_reg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 2;
    localparam int CW = 13;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [CW-1:0]      in_ctrl = '0;
    logic [DW-1:0]      in_pc = '0;
    logic [NS*DW-1:0]   in_rdata = '0;
    logic [DW-1:0]      in_imm = '0;
    logic [NS*AW-1:0]   in_rs = '0;
    logic [2*AW-1:0]    in_rd = '0;
    logic               bubble = 1'b0;
    logic               flush = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [CW-1:0]      out_ctrl;
    logic [DW-1:0]      out_pc;
    logic [NS*DW-1:0]   out_rdata;
    logic [DW-1:0]      out_imm;
    logic [NS*AW-1:0]   out_rs;
    logic [2*AW-1:0]    out_rd;
`ifdef ID_EX_PERF_EN
    logic [31:0]        stall_cnt;
    logic [31:0]        bubble_cnt;
`endif

    typedef struct packed {
        logic          nop;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(
        .DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .CTRL_W(CW), .CTRL_NOP(13'b0)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_pc(in_pc), .in_rdata(in_rdata),
        .in_imm(in_imm), .in_rs(in_rs), .in_rd(in_rd),
        .bubble(bubble), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_pc(out_pc), .out_rdata(out_rdata),
        .out_imm(out_imm), .out_rs(out_rs), .out_rd(out_rd)
`ifdef ID_EX_PERF_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [DW-1:0] pc, input logic [CW-1:0] ctrl);
        in_valid = 1'b1;
        in_pc    = pc;
        in_ctrl  = ctrl;
        in_rdata = {pc + 32'h20, pc + 32'h10};
        in_imm   = ~pc;
        in_rs    = pc[9:0];
        in_rd    = pc[13:4];
    endtask

    function automatic logic [CW-1:0] mk_ctrl(input logic [DW-1:0] pc);
        return {1'b1, pc[11:0]};
    endfunction

    task automatic push(input logic [DW-1:0] pc, input logic [CW-1:0] ctrl);
        exp_t e;
        e.nop = 1'b0; e.ctrl = ctrl; e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic push_nop();
        exp_t e;
        e.nop = 1'b1; e.ctrl = '0; e.pc = '0;
        sb.push_back(e);
    endtask

    // Sample a drain mid-cycle, then advance to just after the next rising edge.
    task automatic tick();
        exp_t e;
        logic [NS*DW-1:0]        er;
        logic [DW+NS*AW+2*AW-1:0] eo;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_drain", 64'(out_valid), 64'd0);
            end else begin
                e  = sb.pop_front();
                er = e.nop ? '0 : {e.pc + 32'h20, e.pc + 32'h10};
                eo = e.nop ? '0 : {~e.pc, e.pc[9:0], e.pc[13:4]};
                check("drain_pc",    64'(out_pc),   64'(e.pc));
                check("drain_ctrl",  64'(out_ctrl), 64'(e.ctrl));
                check("drain_rdata", 64'(out_rdata), 64'(er));
                check("drain_other", 64'({out_imm, out_rs, out_rd}), 64'(eo));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ctrl",  64'(out_ctrl),  64'd0);
        check("rst_pc",    64'(out_pc),    64'd0);
        check("rst_rdata", 64'(out_rdata), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef ID_EX_PERF_EN
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

        // Single transfer, one-cycle latency
        out_ready = 1'b1;
        drive(32'h100, 13'h1A05); push(32'h100, 13'h1A05);
        tick();
        check("lat_valid",    64'(out_valid), 64'd1);
        check("lat_pc",       64'(out_pc),    64'h100);
        check("lat_ctrl",     64'(out_ctrl),  64'h1A05);
        check("lat_in_ready", 64'(in_ready),  64'd1);
        in_valid = 1'b0;
        tick();

        // Back-to-back with backpressure fills the skid entry
        out_ready = 1'b0;
        drive(32'h100, mk_ctrl(32'h100)); push(32'h100, mk_ctrl(32'h100));
        tick();
        drive(32'h104, mk_ctrl(32'h104)); push(32'h104, mk_ctrl(32'h104));
        tick();
        check("skid_in_ready", 64'(in_ready), 64'd0);
        check("skid_hold_pc",  64'(out_pc),   64'h100);
        drive(32'h108, mk_ctrl(32'h108)); push(32'h108, mk_ctrl(32'h108));
        tick();
        check("skid_hold_pc2", 64'(out_pc),   64'h100);
        check("skid_in_ready2", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        check("skid_move_pc",  64'(out_pc),   64'h104);
        check("skid_free",     64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        tick();
        check("skid_empty", 64'(out_valid), 64'd0);
`ifdef ID_EX_PERF_EN
        check("skid_stall_cnt", 64'(stall_cnt), 64'd2);
`endif

        // Two bubble cycles while decode holds 0x200
        bubble = 1'b1;
        drive(32'h200, mk_ctrl(32'h200));
        push_nop(); push_nop(); push(32'h200, mk_ctrl(32'h200));
        tick();
        check("bub_valid",    64'(out_valid), 64'd1);
        check("bub_ctrl",     64'(out_ctrl),  64'd0);
        check("bub_in_ready", 64'(in_ready),  64'd0);
        tick();
        bubble = 1'b0;
        tick();
        check("bub_issue_pc", 64'(out_pc), 64'h200);
        in_valid = 1'b0;
        tick();
`ifdef ID_EX_PERF_EN
        check("bub_cnt", 64'(bubble_cnt), 64'd2);
`endif

        // Flush with M and S valid drops everything, including the flush-cycle input
        out_ready = 1'b0;
        drive(32'h300, mk_ctrl(32'h300));
        tick();
        drive(32'h304, mk_ctrl(32'h304));
        tick();
        check("fl_pre_pc", 64'(out_pc), 64'h300);
        drive(32'h308, mk_ctrl(32'h308));
        flush = 1'b1;
        #1;
        check("fl_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("fl_valid",    64'(out_valid), 64'd0);
        check("fl_ctrl",     64'(out_ctrl),  64'd0);
        check("fl_in_ready2", 64'(in_ready), 64'd1);
`ifdef ID_EX_PERF_EN
        check("fl_stall_cnt",  64'(stall_cnt),  64'd0);
        check("fl_bubble_cnt", 64'(bubble_cnt), 64'd0);
`endif
        out_ready = 1'b1;
        repeat (3) tick();

        // Five stall cycles with M valid
        out_ready = 1'b0;
        drive(32'h400, mk_ctrl(32'h400)); push(32'h400, mk_ctrl(32'h400));
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_pc_hold", 64'(out_pc), 64'h400);
        end
`ifdef ID_EX_PERF_EN
        check("stall_cnt5", 64'(stall_cnt), 64'd5);
`endif
        out_ready = 1'b1;
        tick();

        // Asynchronous reset mid-cycle with M and S valid
        out_ready = 1'b0;
        drive(32'h500, mk_ctrl(32'h500));
        tick();
        drive(32'h504, mk_ctrl(32'h504));
        tick();
        in_valid = 1'b0;
        check("ar_pre_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_ctrl",  64'(out_ctrl),  64'd0);
        check("ar_pc",    64'(out_pc),    64'd0);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("ar_in_ready", 64'(in_ready), 64'd1);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
